// File: rtl/branch_resolve.sv
// Decode-stage control-flow resolver: holds the IF/ID register, resolves BEQ/BNE/J/JAL/JR,
// drives the registered fetch redirect and JAL link write, and squashes wrong-path slots.
module branch_resolve #(
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
  parameter int          SQUASH_DEPTH = 2,
  parameter logic [4:0]  LINK_REG     = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_if,
  input  logic [31:0] npc_if,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [31:0] ir_id,
  output logic [31:0] npc_id,
  output logic        valid_id,
  output logic        pc_update,
  output logic [31:0] pc_i,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic [15:0] redir_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam int         SQ_W       = $clog2(SQUASH_DEPTH + 1);

  logic [SQ_W-1:0] sq_cnt;
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [15:0]     imm;
  logic [25:0]     tgt;
  logic [31:0]     br_target;
  logic [31:0]     j_target;
  logic [31:0]     target;
  logic            taken;
  logic            is_jal;

  assign op        = ir_id[31:26];
  assign funct     = ir_id[5:0];
  assign imm       = ir_id[15:0];
  assign tgt       = ir_id[25:0];
  assign rs_addr   = ir_id[25:21];
  assign rt_addr   = ir_id[20:16];
  assign link_addr = LINK_REG;

  assign br_target = npc_id + {{16{imm[15]}}, imm};
  assign j_target  = {npc_id[31:26], tgt};

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    taken  = 1'b0;
    is_jal = 1'b0;
    target = br_target;
    if (valid_id) begin
      case (op)
        OP_BEQ: taken = (rs_data == rt_data);
        OP_BNE: taken = (rs_data != rt_data);
        OP_J: begin
          taken  = 1'b1;
          target = j_target;
        end
        OP_JAL: begin
          taken  = 1'b1;
          is_jal = 1'b1;
          target = j_target;
        end
        OP_SPECIAL: begin
          if (funct == FUNCT_JR) begin
            taken  = 1'b1;
            target = rs_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_id     <= NOP_WORD;
      npc_id    <= '0;
      valid_id  <= 1'b0;
      pc_update <= 1'b0;
      pc_i      <= '0;
      link_we   <= 1'b0;
      link_data <= '0;
      redir_cnt <= '0;
      sq_cnt    <= '0;
    end else begin
      npc_id    <= npc_if;
      pc_update <= taken;
      link_we   <= is_jal;
      if (taken) begin
        pc_i      <= target;
        redir_cnt <= redir_cnt + 16'd1;
      end
      if (is_jal) link_data <= npc_id;
      // The slot captured on the resolving edge is the first wrong-path slot.
      if (taken) begin
        ir_id    <= NOP_WORD;
        valid_id <= 1'b0;
        sq_cnt   <= SQ_W'(SQUASH_DEPTH - 1);
      end else if (sq_cnt != '0) begin
        ir_id    <= NOP_WORD;
        valid_id <= 1'b0;
        sq_cnt   <= sq_cnt - 1'b1;
      end else begin
        ir_id    <= ir_if;
        valid_id <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: each scenario task drives vectors and compares
// outputs against hand-computed values.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir_if, npc_if, rs_data, rt_data;
  logic [4:0]  rs_addr, rt_addr, link_addr;
  logic [31:0] ir_id, npc_id, pc_i, link_data;
  logic        valid_id, pc_update, link_we;
  logic [15:0] redir_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] IDLE = 32'h2000_0001;

  branch_resolve dut (
    .clk(clk), .rst(rst), .ir_if(ir_if), .npc_if(npc_if),
    .rs_data(rs_data), .rt_data(rt_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .ir_id(ir_id), .npc_id(npc_id), .valid_id(valid_id), .pc_update(pc_update),
    .pc_i(pc_i), .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
    .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] npc);
    ir_if  = ir;
    npc_if = npc;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    checks++; if (ir_id !== NOP)          begin errors++; $display("FAIL reset_ir_id: got %h want %h", ir_id, NOP); end
    checks++; if (npc_id !== 32'd0)       begin errors++; $display("FAIL reset_npc_id: got %h want 0", npc_id); end
    checks++; if (valid_id !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b want 0", valid_id); end
    checks++; if (pc_update !== 1'b0)     begin errors++; $display("FAIL reset_pc_update: got %b want 0", pc_update); end
    checks++; if (pc_i !== 32'd0)         begin errors++; $display("FAIL reset_pc_i: got %h want 0", pc_i); end
    checks++; if (link_we !== 1'b0)       begin errors++; $display("FAIL reset_link_we: got %b want 0", link_we); end
    checks++; if (link_data !== 32'd0)    begin errors++; $display("FAIL reset_link_data: got %h want 0", link_data); end
    checks++; if (redir_cnt !== 16'd0)    begin errors++; $display("FAIL reset_redir_cnt: got %0d want 0", redir_cnt); end
    checks++; if (link_addr !== 5'd31)    begin errors++; $display("FAIL link_addr: got %0d want 31", link_addr); end
    rst = 1'b0;
  endtask

  task automatic test_beq_taken();
    rs_data = 32'd7; rt_data = 32'd7;
    drive(i_type(6'h04, 16'h0005), 32'd4);
    checks++; if (valid_id !== 1'b1)  begin errors++; $display("FAIL beq_capture_valid: got %b want 1", valid_id); end
    checks++; if (rs_addr !== 5'd1 || rt_addr !== 5'd2) begin errors++; $display("FAIL beq_reg_addr: got %0d/%0d want 1/2", rs_addr, rt_addr); end
    drive(32'h2000_0005, 32'd6);
    checks++; if (pc_update !== 1'b1) begin errors++; $display("FAIL beq_pc_update: got %b want 1", pc_update); end
    checks++; if (pc_i !== 32'd9)     begin errors++; $display("FAIL beq_pc_i: got %h want 9", pc_i); end
    checks++; if (redir_cnt !== 16'd1) begin errors++; $display("FAIL beq_redir_cnt: got %0d want 1", redir_cnt); end
    checks++; if (ir_id !== NOP || valid_id !== 1'b0) begin errors++; $display("FAIL beq_squash1: got %h/%b want %h/0", ir_id, valid_id, NOP); end
    drive(32'h2000_0006, 32'd7);
    checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL beq_pulse_width: got %b want 0", pc_update); end
    checks++; if (ir_id !== NOP || valid_id !== 1'b0) begin errors++; $display("FAIL beq_squash2: got %h/%b want %h/0", ir_id, valid_id, NOP); end
    drive(32'h2000_0009, 32'd10);
    checks++; if (ir_id !== 32'h2000_0009 || valid_id !== 1'b1) begin errors++; $display("FAIL beq_target_word: got %h/%b want 20000009/1", ir_id, valid_id); end
    checks++; if (npc_id !== 32'd10)  begin errors++; $display("FAIL beq_target_npc: got %h want 0000000a", npc_id); end
    checks++; if (pc_i !== 32'd9)     begin errors++; $display("FAIL beq_pc_i_hold: got %h want 9", pc_i); end
  endtask

  task automatic test_bne();
    rs_data = 32'd3; rt_data = 32'd3;
    drive(i_type(6'h05, 16'hFFFE), 32'd10);
    drive(IDLE, 32'd11);
    checks++; if (pc_update !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got %b want 0", pc_update); end
    checks++; if (ir_id !== IDLE || valid_id !== 1'b1) begin errors++; $display("FAIL bne_no_squash: got %h/%b want %h/1", ir_id, valid_id, IDLE); end
    rt_data = 32'd4;
    drive(i_type(6'h05, 16'hFFFE), 32'd10);
    drive(IDLE, 32'd11);
    checks++; if (pc_update !== 1'b1 || pc_i !== 32'd8) begin errors++; $display("FAIL bne_taken: got %b/%h want 1/00000008", pc_update, pc_i); end
    checks++; if (redir_cnt !== 16'd2) begin errors++; $display("FAIL bne_redir_cnt: got %0d want 2", redir_cnt); end
    drive(IDLE, 32'd12);
  endtask

  task automatic test_jump_link();
    drive(j_type(6'h02, 26'h40), 32'h0400_0010);
    drive(IDLE, 32'h0400_0011);
    checks++; if (pc_update !== 1'b1 || pc_i !== 32'h0400_0040) begin errors++; $display("FAIL j_target: got %b/%h want 1/04000040", pc_update, pc_i); end
    checks++; if (link_we !== 1'b0)   begin errors++; $display("FAIL j_no_link: got %b want 0", link_we); end
    drive(IDLE, 32'h0400_0012);
    drive(j_type(6'h03, 26'h40), 32'h0400_0010);
    drive(IDLE, 32'h0400_0011);
    checks++; if (link_we !== 1'b1 || link_data !== 32'h0400_0010) begin errors++; $display("FAIL jal_link: got %b/%h want 1/04000010", link_we, link_data); end
    checks++; if (pc_update !== 1'b1 || pc_i !== 32'h0400_0040) begin errors++; $display("FAIL jal_target: got %b/%h want 1/04000040", pc_update, pc_i); end
    drive(IDLE, 32'h0400_0012);
    checks++; if (link_we !== 1'b0 || pc_update !== 1'b0) begin errors++; $display("FAIL jal_pulse_width: got %b/%b want 0/0", link_we, pc_update); end
    checks++; if (redir_cnt !== 16'd4) begin errors++; $display("FAIL jal_redir_cnt: got %0d want 4", redir_cnt); end
  endtask

  task automatic test_squash_shadow();
    rs_data = 32'h20; rt_data = 32'h20;
    drive({6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 6'h08}, 32'h100);
    drive(i_type(6'h04, 16'h0003), 32'h101);
    checks++; if (pc_update !== 1'b1 || pc_i !== 32'h20) begin errors++; $display("FAIL jr_target: got %b/%h want 1/00000020", pc_update, pc_i); end
    drive(i_type(6'h04, 16'h0003), 32'h102);
    checks++; if (pc_update !== 1'b0 || valid_id !== 1'b0) begin errors++; $display("FAIL shadow_slot1: got %b/%b want 0/0", pc_update, valid_id); end
    drive(IDLE, 32'h21);
    checks++; if (pc_update !== 1'b0 || valid_id !== 1'b1) begin errors++; $display("FAIL shadow_slot2: got %b/%b want 0/1", pc_update, valid_id); end
    checks++; if (redir_cnt !== 16'd5) begin errors++; $display("FAIL shadow_redir_cnt: got %0d want 5", redir_cnt); end
  endtask

  task automatic test_reset_mid_squash();
    drive(j_type(6'h03, 26'h80), 32'h55);
    drive(IDLE, 32'h56);
    checks++; if (pc_update !== 1'b1 || link_we !== 1'b1) begin errors++; $display("FAIL pre_reset_pulses: got %b/%b want 1/1", pc_update, link_we); end
    rst = 1'b1;
    drive(IDLE, 32'h57);
    checks++; if (pc_update !== 1'b0 || link_we !== 1'b0 || valid_id !== 1'b0) begin errors++; $display("FAIL mid_reset_clear: got %b/%b/%b want 0/0/0", pc_update, link_we, valid_id); end
    checks++; if (redir_cnt !== 16'd0 || link_data !== 32'd0) begin errors++; $display("FAIL mid_reset_state: got %0d/%h want 0/0", redir_cnt, link_data); end
    rst = 1'b0;
    drive(32'h2000_00AA, 32'h81);
    checks++; if (ir_id !== 32'h2000_00AA || valid_id !== 1'b1) begin errors++; $display("FAIL post_reset_capture: got %h/%b want 200000aa/1", ir_id, valid_id); end
  endtask

  task automatic test_redir_wrap();
    force dut.redir_cnt = 16'hFFFE;
    #1;
    release dut.redir_cnt;
    drive(j_type(6'h02, 26'h10), 32'h200);
    drive(IDLE, 32'h201);
    checks++; if (redir_cnt !== 16'hFFFF) begin errors++; $display("FAIL redir_cnt_max: got %h want ffff", redir_cnt); end
    drive(IDLE, 32'h202);
    drive(j_type(6'h02, 26'h10), 32'h11);
    drive(IDLE, 32'h12);
    checks++; if (redir_cnt !== 16'h0000 || pc_update !== 1'b1) begin errors++; $display("FAIL redir_cnt_wrap: got %h/%b want 0000/1", redir_cnt, pc_update); end
  endtask

  initial begin
    rst = 1'b1; ir_if = NOP; npc_if = '0; rs_data = '0; rt_data = '0;
    test_reset();
    test_beq_taken();
    test_bne();
    test_jump_link();
    test_squash_shadow();
    test_reset_mid_squash();
    test_redir_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
